// File: rtl/avalon_hex_key_pio.sv
// Avalon-MM slave combining seven-segment digit drivers with a debounced,
// edge-capturing push-button block that raises a maskable level interrupt.
module avalon_hex_key_pio #(
  parameter int N_HEX           = 8,
  parameter int N_KEY           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [3:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [N_KEY-1:0]     key_export,
  output logic [7*N_HEX-1:0]   hex_export
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEY-1:0] KEY_IDLE = {N_KEY{KEY_ACTIVE_LOW}};
  localparam logic [6:0]       SEG_DARK = {7{SEG_ACTIVE_LOW}};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  // ctrl[0]=DECODE, ctrl[1]=BLANK; result is in pin polarity
  function automatic logic [6:0] seg_drive(input logic [1:0] ctrl, input logic [6:0] dig);
    logic [6:0] lit;
    if (ctrl[1])      lit = 7'h00;
    else if (ctrl[0]) lit = seg_decode(dig[3:0]);
    else              lit = dig;
    seg_drive = SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

  logic [1:0]       ctrl_q;
  logic [N_KEY-1:0] mask_q;
  logic [N_KEY-1:0] edge_q;
  logic [N_KEY-1:0] stable_q;
  logic [6:0]       dig_q [N_HEX];
  logic [CNT_W-1:0] cnt_q [N_KEY];
  logic [N_KEY-1:0] key_p0, key_p1;
  logic [N_KEY-1:0] pressed, settle, press, edge_clr;
  logic [7*N_HEX-1:0] hex_next;
  logic [31:0]      rd_mux;
  logic             wr_ctrl, wr_edge, wr_mask;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign wr_ctrl  = avs_write && (avs_address == 4'd0);
  assign wr_edge  = avs_write && (avs_address == 4'd2);
  assign wr_mask  = avs_write && (avs_address == 4'd3);
  assign edge_clr = wr_edge ? avs_writedata[N_KEY-1:0] : '0;

  // Stage p0/p1: two-flop synchroniser, reset to the released pin level
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_p0 <= KEY_IDLE;
      key_p1 <= KEY_IDLE;
    end else begin
      key_p0 <= key_export;
      key_p1 <= key_p0;
    end
  end

  assign pressed = KEY_ACTIVE_LOW ? ~key_p1 : key_p1;

  always_comb begin
    settle = '0;
    for (int k = 0; k < N_KEY; k++)
      settle[k] = (pressed[k] != stable_q[k]) && (cnt_q[k] == CNT_MAX);
  end

  assign press = settle & pressed;

  // Debounce stage: stable state flips only after a full run of disagreement
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < N_KEY; k++) cnt_q[k] <= '0;
      stable_q <= '0;
      edge_q   <= '0;
    end else begin
      for (int k = 0; k < N_KEY; k++) begin
        if (pressed[k] == stable_q[k] || cnt_q[k] == CNT_MAX) cnt_q[k] <= '0;
        else                                                   cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
      stable_q <= stable_q ^ settle;
      edge_q   <= (edge_q & ~edge_clr) | press;
    end
  end

  assign irq = |(edge_q & mask_q);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl_q <= '0;
      mask_q <= '0;
      for (int i = 0; i < N_HEX; i++) dig_q[i] <= '0;
    end else begin
      if (wr_ctrl) ctrl_q <= avs_writedata[1:0];
      if (wr_mask) mask_q <= avs_writedata[N_KEY-1:0];
      for (int i = 0; i < N_HEX; i++)
        if (avs_write && avs_address == 4'(4 + i)) dig_q[i] <= avs_writedata[6:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      4'd0: rd_mux[1:0]       = ctrl_q;
      4'd1: rd_mux[N_KEY-1:0] = stable_q;
      4'd2: rd_mux[N_KEY-1:0] = edge_q;
      4'd3: rd_mux[N_KEY-1:0] = mask_q;
      default: begin
        for (int i = 0; i < N_HEX; i++)
          if (avs_address == 4'(4 + i)) rd_mux[6:0] = dig_q[i];
      end
    endcase
  end

  always_comb begin
    hex_next = '0;
    for (int i = 0; i < N_HEX; i++) hex_next[7*i +: 7] = seg_drive(ctrl_q, dig_q[i]);
  end

  // Output stage: registered read data and segment pins
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
      hex_export   <= {N_HEX{SEG_DARK}};
    end else begin
      if (avs_read) avs_readdata <= rd_mux;
      hex_export <= hex_next;
    end
  end

endmodule

// File: tb/tb_avalon_hex_key_pio.sv
// Directed bench for avalon_hex_key_pio: register table plus hand-timed key,
// interrupt and reset sequences with DEBOUNCE_CYCLES=4.
module tb_avalon_hex_key_pio;

  localparam int N_HEX = 8;
  localparam int N_KEY = 4;
  localparam int OP_WR = 0;
  localparam int OP_RD = 1;
  localparam int OP_HEX = 2;
  localparam logic [63:0] HEX_DARK = {8'h00, {56{1'b1}}};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              irq;
  logic [N_KEY-1:0]  key_export;
  logic [7*N_HEX-1:0] hex_export;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  avalon_hex_key_pio #(
    .N_HEX(N_HEX), .N_KEY(N_KEY), .DEBOUNCE_CYCLES(4),
    .KEY_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(reset_n),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .key_export(key_export),
    .hex_export(hex_export)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic add(input int op, input logic [3:0] addr, input logic [31:0] data,
                     input logic [31:0] exp, input string name);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic read_check(input logic [3:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    bus_read(addr, rd);
    check(name, 64'(rd), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    // register map / segment table; hex entries compare digits 1..0 = hex_export[13:0]
    add(OP_WR, 4'd0, 32'h1,        32'h0,    "");
    add(OP_WR, 4'd4, 32'h8,        32'h0,    "");
    add(OP_HEX, 4'd0, 32'h0,       32'h2000, "hex_dec_8");
    add(OP_WR, 4'd5, 32'hF,        32'h0,    "");
    add(OP_HEX, 4'd0, 32'h0,       32'h0700, "hex_dec_F");
    add(OP_RD, 4'd4, 32'h0,        32'h8,    "rd_dig0");
    add(OP_RD, 4'd5, 32'h0,        32'hF,    "rd_dig1");
    add(OP_RD, 4'd0, 32'h0,        32'h1,    "rd_ctrl");
    add(OP_WR, 4'd0, 32'h3,        32'h0,    "");
    add(OP_HEX, 4'd0, 32'h0,       32'h3FFF, "hex_blank");
    add(OP_WR, 4'd0, 32'h0,        32'h0,    "");
    add(OP_WR, 4'd4, 32'hFFFFFF7F, 32'h0,    "");
    add(OP_WR, 4'd5, 32'h01,       32'h0,    "");
    add(OP_HEX, 4'd0, 32'h0,       32'h3F00, "hex_raw");
    add(OP_RD, 4'd4, 32'h0,        32'h7F,   "rd_dig0_upper0");
    add(OP_WR, 4'd1, 32'hF,        32'h0,    "");
    add(OP_RD, 4'd1, 32'h0,        32'h0,    "keys_ro");
    add(OP_WR, 4'd15, 32'h12345678, 32'h0,   "");
    add(OP_RD, 4'd15, 32'h0,       32'h0,    "rd_unmapped15");
    add(OP_WR, 4'd12, 32'hFF,      32'h0,    "");
    add(OP_RD, 4'd12, 32'h0,       32'h0,    "rd_unmapped12");
    add(OP_WR, 4'd3, 32'hFFFF,     32'h0,    "");
    add(OP_RD, 4'd3, 32'h0,        32'hF,    "rd_mask");
    add(OP_WR, 4'd3, 32'h0,        32'h0,    "");
    add(OP_RD, 4'd3, 32'h0,        32'h0,    "rd_mask_clr");
    add(OP_WR, 4'd2, 32'hF,        32'h0,    "");
    add(OP_RD, 4'd2, 32'h0,        32'h0,    "rd_edge_idle");
    add(OP_WR, 4'd0, 32'h5,        32'h0,    "");
    add(OP_RD, 4'd0, 32'h0,        32'h1,    "rd_ctrl_2bit");
    add(OP_WR, 4'd0, 32'h0,        32'h0,    "");

    reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; key_export = '1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset state
    check("reset_hex", 64'(hex_export), HEX_DARK);
    check("reset_irq", 64'(irq), 64'h0);
    for (int a = 0; a < 16; a++) read_check(4'(a), 32'h0, "reset_read");

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR: bus_write(vecs[i].addr, vecs[i].data);
        OP_RD: begin
          bus_read(vecs[i].addr, rd);
          check(vecs[i].name, 64'(rd), 64'(vecs[i].exp));
        end
        default: begin
          @(negedge clk);
          check(vecs[i].name, 64'(hex_export[13:0]), 64'(vecs[i].exp[13:0]));
        end
      endcase
    end

    // segment register is exactly one cycle behind the DIG write
    bus_write(4'd6, 32'h7F);
    check("hex_dig2_before", 64'(hex_export[20:14]), 64'h7F);
    @(negedge clk);
    check("hex_dig2_after", 64'(hex_export[20:14]), 64'h00);

    // 3-cycle glitch is rejected
    @(negedge clk); key_export[0] = 1'b0;
    repeat (3) @(negedge clk);
    key_export[0] = 1'b1;
    repeat (10) @(negedge clk);
    read_check(4'd1, 32'h0, "glitch_keys");
    read_check(4'd2, 32'h0, "glitch_edge");

    // long press: KEYS updates 6 cycles after the fall, seen on readdata one cycle later
    @(negedge clk);
    key_export[0] = 1'b0; avs_address = 4'd1; avs_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("keys_latency", 64'(avs_readdata), (k >= 7) ? 64'h1 : 64'h0);
    end
    avs_read = 1'b0;
    repeat (12) @(negedge clk);
    read_check(4'd1, 32'h1, "press_keys");
    read_check(4'd2, 32'h1, "press_edge");

    // clear, release sets nothing
    bus_write(4'd2, 32'h1);
    read_check(4'd2, 32'h0, "edge_w1c");
    key_export[0] = 1'b1;
    repeat (10) @(negedge clk);
    read_check(4'd1, 32'h0, "release_keys");
    read_check(4'd2, 32'h0, "release_no_edge");

    // irq on press, cleared by EDGE write
    bus_write(4'd3, 32'h1);
    check("irq_masked_idle", 64'(irq), 64'h0);
    @(negedge clk); key_export[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("irq_latency", 64'(irq), (k >= 6) ? 64'h1 : 64'h0);
    end
    bus_write(4'd2, 32'h1);
    check("irq_clear", 64'(irq), 64'h0);

    // set wins over a coincident clear
    key_export[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("irq_after_release", 64'(irq), 64'h0);
    read_check(4'd2, 32'h0, "edge_before_coincide");
    @(negedge clk); key_export[0] = 1'b0;
    repeat (5) @(negedge clk);
    avs_address = 4'd2; avs_writedata = 32'h1; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    check("irq_set_wins", 64'(irq), 64'h1);
    read_check(4'd2, 32'h1, "edge_set_wins");

    // debounced release leaves EDGE and irq alone
    key_export[0] = 1'b1;
    repeat (10) @(negedge clk);
    read_check(4'd1, 32'h0, "release2_keys");
    read_check(4'd2, 32'h1, "release2_edge");
    check("release2_irq", 64'(irq), 64'h1);

    // reset mid-debounce of key1
    @(negedge clk); key_export[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_readdata", 64'(avs_readdata), 64'h0);
    check("rst_hex", 64'(hex_export), HEX_DARK);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; avs_address = 4'd1; avs_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("rst_keys_latency", 64'(avs_readdata), (k >= 7) ? 64'h2 : 64'h0);
    end
    avs_read = 1'b0;
    read_check(4'd0, 32'h0, "rst_ctrl");
    read_check(4'd2, 32'h2, "rst_edge_key1");
    read_check(4'd3, 32'h0, "rst_mask");
    read_check(4'd4, 32'h0, "rst_dig0");
    read_check(4'd6, 32'h0, "rst_dig2");
    check("rst_irq_after", 64'(irq), 64'h0);
    check("rst_hex_after", 64'(hex_export), HEX_DARK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
